ndata_stream_arbiter: RTL and testbench

Packet-granular round-robin arbiter that merges `NUM_INPUTS` ndata streams into one, so several producers can share a single downstream datapath such as the stream width converter or an outbound port. A grant is held from the first accepted beat of a packet until its `last` beat is accepted, so packets are never interleaved. The output is a single registered stage with full one-beat-per-cycle throughput, including between packets from different inputs.

---
 rtl/ndata_stream_arbiter_if.sv | 14 +
 rtl/ndata_stream_arbiter.sv | 127 ++++++++++++
 tb/tb_ndata_stream_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ndata_stream_arbiter_if.sv
// ndata stream bundle: NUM_ELEMENTS lanes of data_t with per-lane keep, packet last, valid/ready.
interface ndata_i #(
  parameter type data_t       = logic [7:0],
  parameter int  NUM_ELEMENTS = 1
);
  data_t [NUM_ELEMENTS-1:0] data;
  logic  [NUM_ELEMENTS-1:0] keep;
  logic                     last;
  logic                     valid;
  logic                     ready;

  modport m (output data, output keep, output last, output valid, input  ready);
  modport s (input  data, input  keep, input  last, input  valid, output ready);
endinterface

// File: rtl/ndata_stream_arbiter.sv
// Packet-granular round-robin merge of NUM_INPUTS ndata streams into one registered output.
// Latency 1 cycle; full throughput; input readies drop while the output register is stalled.
module ndata_stream_arbiter #(
  parameter type data_t     = logic [7:0],
  parameter int  NUM_INPUTS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  ndata_i.s                     in [NUM_INPUTS],
  ndata_i.m                     out,
  output logic [NUM_INPUTS-1:0] grant,
  output logic                  busy
);

  localparam int NE = $bits(out.keep);
  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef logic [IW-1:0] idx_t;
  typedef enum logic {IDLE, LOCKED} state_t;

  if (NUM_INPUTS < 1) begin : g_bad_inputs
    $error("ndata_stream_arbiter: NUM_INPUTS must be at least 1");
  end
  if ($bits(out.data) != NE * $bits(data_t)) begin : g_bad_width
    $error("ndata_stream_arbiter: element count/type mismatch on out");
  end

  data_t [NE-1:0]        in_dat  [NUM_INPUTS];
  logic  [NE-1:0]        in_keep [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] in_vld;
  logic [NUM_INPUTS-1:0] in_last;
  logic [NUM_INPUTS-1:0] in_rdy;

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_in
    assign in_dat[gi]   = in[gi].data;
    assign in_keep[gi]  = in[gi].keep;
    assign in_last[gi]  = in[gi].last;
    assign in_vld[gi]   = in[gi].valid;
    assign in[gi].ready = in_rdy[gi];
  end

  state_t                state_q, state_d;
  idx_t                  owner_q, owner_d;
  idx_t                  rr_ptr_q, rr_ptr_d;
  logic [NUM_INPUTS-1:0] grant_q, grant_d;
  logic                  out_vld_q;
  data_t [NE-1:0]        out_dat_q;
  logic  [NE-1:0]        out_keep_q;
  logic                  out_last_q;

  logic accept;
  logic any_vld;
  logic hs;
  idx_t sel;
  idx_t cand;
  idx_t cur;

  always_comb begin
    accept   = !out_vld_q || out.ready;
    any_vld  = |in_vld;
    sel      = rr_ptr_q;
    cand     = '0;
    in_rdy   = '0;
    hs       = 1'b0;
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;

    // Walk from the furthest candidate back to rr_ptr so the nearest valid one wins.
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      cand = idx_t'((int'(rr_ptr_q) + k) % NUM_INPUTS);
      if (in_vld[cand]) sel = cand;
    end

    cur = (state_q == LOCKED) ? owner_q : sel;
    if (state_q == LOCKED || any_vld) in_rdy[cur] = accept;
    hs = in_rdy[cur] && in_vld[cur];

    if (hs) begin
      if (in_last[cur]) begin
        state_d  = IDLE;
        grant_d  = '0;
        rr_ptr_d = (cur == idx_t'(NUM_INPUTS - 1)) ? '0 : idx_t'(cur + 1'b1);
      end else begin
        state_d      = LOCKED;
        owner_d      = cur;
        grant_d      = '0;
        grant_d[cur] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      if (hs) begin
        out_vld_q  <= 1'b1;
        out_dat_q  <= in_dat[cur];
        out_keep_q <= in_keep[cur];
        out_last_q <= in_last[cur];
      end else if (out.ready) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign out.valid = out_vld_q;
  assign out.data  = out_dat_q;
  assign out.keep  = out_keep_q;
  assign out.last  = out_last_q;
  assign grant     = grant_q;
  assign busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_ndata_stream_arbiter.sv
// Directed bench for ndata_stream_arbiter with four 2x8-bit requesters.
module tb_ndata_stream_arbiter;
  typedef logic [7:0] byte_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ndata_i #(.data_t(byte_t), .NUM_ELEMENTS(2)) in_if [4] ();
  ndata_i #(.data_t(byte_t), .NUM_ELEMENTS(2)) out_if ();

  logic [3:0] grant;
  logic       busy;
  logic       out_rdy;
  logic [3:0] vld, lst, rdy;
  byte_t      dd [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_in
    assign in_if[gi].valid = vld[gi];
    assign in_if[gi].data  = {dd[gi], dd[gi]};
    assign in_if[gi].keep  = dd[gi][1:0];
    assign in_if[gi].last  = lst[gi];
    assign rdy[gi]         = in_if[gi].ready;
  end
  assign out_if.ready = out_rdy;

  ndata_stream_arbiter #(.data_t(byte_t), .NUM_INPUTS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in_if),
    .out   (out_if),
    .grant (grant),
    .busy  (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(int i, logic v, byte_t d, logic l);
    vld[i] = v;
    dd[i]  = d;
    lst[i] = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each beat carries its byte in both lanes and its low two bits as keep.
  task automatic chk_out(string tag, byte_t d, logic l);
    byte_t dk;
    dk = d;
    chk({tag, ".vld"},  32'(out_if.valid), 32'd1);
    chk({tag, ".dat"},  32'(out_if.data),  32'({d, d}));
    chk({tag, ".keep"}, 32'(out_if.keep),  32'(dk[1:0]));
    chk({tag, ".last"}, 32'(out_if.last),  32'(l));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vld     = '0;
    lst     = '0;
    dd      = '{default: 8'h00};
    out_rdy = 1'b1;

    #1 rst = 1'b1;
    #1;
    chk("rst.vld",   32'(out_if.valid), 32'd0);
    chk("rst.grant", 32'(grant),        32'd0);
    chk("rst.busy",  32'(busy),         32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single-beat round robin, all four requesting
    for (int i = 0; i < 4; i++) drive(i, 1'b1, byte_t'(8'hA0 + i), 1'b1);
    for (int c = 0; c < 6; c++) begin
      #1 chk("rr.rdy", 32'(rdy), 32'(4'b0001 << (c % 4)));
      tick();
      chk_out("rr", byte_t'(8'hA0 + (c % 4)), 1'b1);
      chk("rr.busy", 32'(busy), 32'd0);
    end
    vld = '0;

    // Packet lock on input 1 while input 2 waits
    drive(1, 1'b1, 8'h11, 1'b0);
    #1 chk("lk.rdy1", 32'(rdy), 32'b0010);
    tick();
    chk_out("lk1", 8'h11, 1'b0);
    chk("lk1.grant", 32'(grant), 32'b0010);
    chk("lk1.busy",  32'(busy),  32'd1);
    drive(1, 1'b1, 8'h12, 1'b0);
    drive(2, 1'b1, 8'h21, 1'b1);
    #1 chk("lk.rdy2", 32'(rdy), 32'b0010);
    tick();
    chk_out("lk2", 8'h12, 1'b0);
    chk("lk2.grant", 32'(grant), 32'b0010);
    drive(1, 1'b1, 8'h13, 1'b1);
    #1 chk("lk.rdy3", 32'(rdy), 32'b0010);
    tick();
    chk_out("lk3", 8'h13, 1'b1);
    chk("lk3.grant", 32'(grant), 32'd0);
    chk("lk3.busy",  32'(busy),  32'd0);
    drive(1, 1'b0, 8'h00, 1'b0);
    #1 chk("lk.rdy4", 32'(rdy), 32'b0100);
    tick();
    chk_out("lk4", 8'h21, 1'b1);
    drive(2, 1'b0, 8'h00, 1'b0);

    // Downstream stall in the middle of a packet from input 3
    drive(3, 1'b1, 8'h31, 1'b0);
    #1 chk("bp.rdy0", 32'(rdy), 32'b1000);
    tick();
    chk_out("bp0", 8'h31, 1'b0);
    chk("bp0.grant", 32'(grant), 32'b1000);
    drive(3, 1'b1, 8'h32, 1'b0);
    out_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1 chk("bp.stall_rdy", 32'(rdy), 32'd0);
      tick();
      chk_out("bp.hold", 8'h31, 1'b0);
      chk("bp.grant", 32'(grant), 32'b1000);
    end
    out_rdy = 1'b1;
    #1 chk("bp.resume_rdy", 32'(rdy), 32'b1000);
    tick();
    chk_out("bp1", 8'h32, 1'b0);
    drive(3, 1'b1, 8'h33, 1'b1);
    #1 chk("bp.rdy2", 32'(rdy), 32'b1000);
    tick();
    chk_out("bp2", 8'h33, 1'b1);
    chk("bp2.grant", 32'(grant), 32'd0);
    drive(3, 1'b0, 8'h00, 1'b0);

    // rr_ptr is 0: lone input 2 moves it to 3, then wrap-around skips
    drive(2, 1'b1, 8'h24, 1'b1);
    #1 chk("ws.rdy2", 32'(rdy), 32'b0100);
    tick();
    chk_out("ws2", 8'h24, 1'b1);
    drive(2, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b1, 8'h16, 1'b1);
    #1 chk("ws.rdy1", 32'(rdy), 32'b0010);
    tick();
    chk_out("ws1", 8'h16, 1'b1);
    drive(1, 1'b0, 8'h00, 1'b0);
    drive(0, 1'b1, 8'h07, 1'b1);
    #1 chk("ws.rdy0", 32'(rdy), 32'b0001);
    tick();
    chk_out("ws0", 8'h07, 1'b1);
    for (int i = 0; i < 4; i++) drive(i, 1'b1, byte_t'(8'hB0 + i), 1'b1);
    #1 chk("ws.ptr1", 32'(rdy), 32'b0010);
    tick();
    chk_out("wsb", 8'hB1, 1'b1);
    vld = '0;

    // Asynchronous reset two beats into a four-beat packet on input 0
    drive(0, 1'b1, 8'h01, 1'b0);
    #1 chk("mr.rdy0", 32'(rdy), 32'b0001);
    tick();
    chk_out("mr0", 8'h01, 1'b0);
    chk("mr0.busy", 32'(busy), 32'd1);
    drive(0, 1'b1, 8'h02, 1'b0);
    #1 chk("mr.rdy1", 32'(rdy), 32'b0001);
    tick();
    chk_out("mr1", 8'h02, 1'b0);
    chk("mr1.grant", 32'(grant), 32'b0001);
    vld = '0;
    #2 rst = 1'b1;
    #1;
    chk("mr.rst_vld",   32'(out_if.valid), 32'd0);
    chk("mr.rst_grant", 32'(grant),        32'd0);
    chk("mr.rst_busy",  32'(busy),         32'd0);
    #2 rst = 1'b0;
    tick();
    chk("mr.post_busy",  32'(busy),  32'd0);
    chk("mr.post_grant", 32'(grant), 32'd0);
    drive(0, 1'b1, 8'h05, 1'b1);
    drive(1, 1'b1, 8'h15, 1'b1);
    #1 chk("mr.rdy_a", 32'(rdy), 32'b0001);
    tick();
    chk_out("mra", 8'h05, 1'b1);
    chk("mra.busy", 32'(busy), 32'd0);
    drive(0, 1'b0, 8'h00, 1'b0);
    #1 chk("mr.rdy_b", 32'(rdy), 32'b0010);
    tick();
    chk_out("mrb", 8'h15, 1'b1);
    vld = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
